// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - splits one wide input word into NumBeats narrow valid/ready output beats
//
// Optional build macro: STREAM_SERIALIZER_MSB_FIRST_EN
//   undefined (default): beat k carries buffer slice k (LSB first)
//   defined            : beat k carries buffer slice NumBeats-1-k (MSB first,
//                        so any zero padding shows up in the first beat)
// beat_o / last_o always count 0..NumBeats-1 regardless of the macro.

module stream_serializer #(
  parameter int InWidth      = 64,
  parameter int OutWidth     = 16,
  // Derived; leave at their defaults.
  parameter int NumBeats     = (InWidth + OutWidth - 1) / OutWidth,
  parameter int BeatIdxWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [InWidth-1:0]      data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [OutWidth-1:0]     data_o,
  output logic                    last_o,
  output logic [BeatIdxWidth-1:0] beat_o
);

  localparam int BufWidth = NumBeats * OutWidth;
  localparam logic [BeatIdxWidth-1:0] LastBeat = BeatIdxWidth'(NumBeats - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [BeatIdxWidth-1:0] beat_q, beat_d;
  logic [BufWidth-1:0]     buf_q, buf_d;

  logic [BufWidth-1:0]     data_ext;
  logic [BeatIdxWidth-1:0] slice_idx;
  logic [OutWidth-1:0]     slice_data;
  logic                    is_last;

  // Zero-extend the incoming word to a whole number of beats.
  always_comb begin
    data_ext                = '0;
    data_ext[InWidth-1:0]   = data_i;
  end

  // Map the beat counter onto the buffer slice that is emitted for it.
  always_comb begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    slice_idx = LastBeat - beat_q;
`else
    slice_idx = beat_q;
`endif
  end

  // Slice mux; written as a compare loop so non-power-of-two beat counts stay in range.
  always_comb begin
    slice_data = '0;
    for (int k = 0; k < NumBeats; k++) begin
      if (slice_idx == BeatIdxWidth'(k)) begin
        slice_data = buf_q[k*OutWidth +: OutWidth];
      end
    end
  end

  // State, beat counter and word buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    is_last = (state_q == BUSY) && (beat_q == LastBeat);

    valid_o = (state_q == BUSY);
    last_o  = is_last;
    beat_o  = beat_q;
    // Idle output is held at zero so stale buffer contents never leak out.
    data_o  = (state_q == BUSY) ? slice_data : '0;

    // In BUSY the next word is only taken together with the final beat,
    // which is what lets back-to-back words stream without a bubble.
    if (flush_i) begin
      ready_o = 1'b0;
    end else if (state_q == IDLE) begin
      ready_o = 1'b1;
    end else begin
      ready_o = ready_i && is_last;
    end

    if (flush_i) begin
      state_d = IDLE;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            buf_d   = data_ext;
            beat_d  = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (ready_i) begin
            if (is_last) begin
              beat_d = '0;
              if (valid_i) begin
                buf_d   = data_ext;
                state_d = BUSY;
              end else begin
                state_d = IDLE;
              end
            end else begin
              beat_d = beat_q + BeatIdxWidth'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  if (InWidth < 1 || OutWidth < 1) begin : gen_width_check
    $fatal(1, "stream_serializer: InWidth and OutWidth must both be >= 1");
  end

  if (NumBeats != (InWidth + OutWidth - 1) / OutWidth) begin : gen_beats_check
    $fatal(1, "stream_serializer: NumBeats is derived and must not be overridden");
  end

`ifndef COMMON_CELLS_ASSERTS_OFF
  // A presented beat may not be withdrawn while the sink stalls (flush excepted).
  a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> valid_o);

  // A stalled beat keeps its payload and position.
  a_beat_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> ($stable(data_o) && $stable(beat_o) && $stable(last_o)));

  // The counter never runs past the final beat.
  a_beat_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(beat_o) < NumBeats);
`endif
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - scoreboard bench for stream_serializer (40/16 and 8/8 configs)

module tb_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 40-bit in, 16-bit out: three beats.
  logic        flush40, valid40_i, ready40_o, valid40_o, ready40_i, last40_o;
  logic [39:0] data40_i;
  logic [15:0] data40_o;
  logic [1:0]  beat40_o;

  // 8-bit in, 8-bit out: single beat.
  logic        flush8, valid8_i, ready8_o, valid8_o, ready8_i, last8_o;
  logic [7:0]  data8_i, data8_o;
  logic [0:0]  beat8_o;

  stream_serializer #(.InWidth(40), .OutWidth(16)) u_dut40 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush40),
    .valid_i(valid40_i), .ready_o(ready40_o), .data_i(data40_i),
    .valid_o(valid40_o), .ready_i(ready40_i), .data_o(data40_o),
    .last_o(last40_o), .beat_o(beat40_o)
  );

  stream_serializer #(.InWidth(8), .OutWidth(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush8),
    .valid_i(valid8_i), .ready_o(ready8_o), .data_i(data8_i),
    .valid_o(valid8_o), .ready_i(ready8_i), .data_o(data8_o),
    .last_o(last8_o), .beat_o(beat8_o)
  );

  int errors = 0;
  int checks = 0;

  // Expected beats packed as {last, beat, data}.
  logic [18:0] q40[$];
  logic [9:0]  q8[$];
  logic [18:0] exp40;
  logic [9:0]  exp8;

  int run40 = 0, last_run40 = 0;
  int run8  = 0, last_run8  = 0;

  localparam logic [39:0] WordA = 40'hAB_CDEF_1234;
  localparam logic [39:0] WordB = 40'h12_3456_789A;
  localparam logic [39:0] WordF = 40'hFF_EEEE_DDDD;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Beat slicing of a zero-extended 48-bit buffer in emission order.
  function automatic void push_word40(input logic [39:0] w);
    logic [47:0] ext;
    int          s;
    ext = {8'h00, w};
    for (int k = 0; k < 3; k++) begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
      s = 2 - k;
`else
      s = k;
`endif
      q40.push_back({(k == 2), 2'(k), ext[s*16 +: 16]});
    end
  endfunction

  // Scoreboard monitor: compare each accepted beat against the queue head.
  always @(negedge clk) begin
    if (rst_n && valid40_o && ready40_i && !flush40) begin
      if (q40.size() == 0) begin
        check("beat40 unexpected", {45'd0, last40_o, beat40_o, data40_o}, 64'd0);
      end else begin
        exp40 = q40.pop_front();
        check("beat40", {45'd0, last40_o, beat40_o, data40_o}, {45'd0, exp40});
      end
    end
    if (rst_n && valid8_o && ready8_i && !flush8) begin
      if (q8.size() == 0) begin
        check("beat8 unexpected", {54'd0, last8_o, beat8_o, data8_o}, 64'd0);
      end else begin
        exp8 = q8.pop_front();
        check("beat8", {54'd0, last8_o, beat8_o, data8_o}, {54'd0, exp8});
      end
    end
    if (valid40_o) run40++;
    else if (run40 != 0) begin last_run40 = run40; run40 = 0; end
    if (valid8_o) run8++;
    else if (run8 != 0) begin last_run8 = run8; run8 = 0; end
  end

  task automatic send40(input logic [39:0] w, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    data40_i  = w;
    valid40_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready40_o) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    check("send40 handshake", {63'd0, ok}, 64'd1);
    if (ok) push_word40(w);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle40();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!valid40_o && q40.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain40", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    flush40 = 1'b0; valid40_i = 1'b0; ready40_i = 1'b1; data40_i = '0;
    flush8  = 1'b0; valid8_i  = 1'b0; ready8_i  = 1'b1; data8_i  = '0;
    #3;
    check("reset valid_o",  {63'd0, valid40_o}, 64'd0);
    check("reset ready_o",  {63'd0, ready40_o}, 64'd1);
    check("reset last_o",   {63'd0, last40_o},  64'd0);
    check("reset beat_o",   {62'd0, beat40_o},  64'd0);
    check("reset data_o",   {48'd0, data40_o},  64'd0);
    check("reset8 ready_o", {63'd0, ready8_o},  64'd1);
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic split with one-cycle latency.
    send40(WordA, waited);
    valid40_i = 1'b0;
    check("idle accept wait", 64'(waited), 64'd0);
    @(negedge clk);
    check("first beat latency valid", {63'd0, valid40_o}, 64'd1);
    check("first beat index", {62'd0, beat40_o}, 64'd0);
    wait_idle40();
    check("split run length", 64'(last_run40), 64'd3);

    // Back-to-back: ready_o only in A's last-beat cycle, no bubble.
    send40(WordA, waited);
    send40(WordB, waited);
    valid40_i = 1'b0;
    check("b2b ready_o wait", 64'(waited), 64'd2);
    wait_idle40();
    check("b2b run length", 64'(last_run40), 64'd6);

    // Backpressure on beat 1 for four cycles.
    send40(WordA, waited);
    valid40_i = 1'b0;
    @(posedge clk);
    #1;
    ready40_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall data_o",  {48'd0, data40_o},  64'h0000_0000_0000_CDEF);
      check("stall beat_o",  {62'd0, beat40_o},  64'd1);
      check("stall valid_o", {63'd0, valid40_o}, 64'd1);
    end
    @(posedge clk);
    #1;
    ready40_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post-stall beat_o", {62'd0, beat40_o}, 64'd2);
    wait_idle40();
    check("stall run length", 64'(last_run40), 64'd7);

    // Flush during beat 1 with a competing input word.
    send40(WordA, waited);
    valid40_i = 1'b0;
    @(posedge clk);
    #1;
    flush40   = 1'b1;
    valid40_i = 1'b1;
    data40_i  = WordF;
    @(negedge clk);
    check("flush ready_o forced", {63'd0, ready40_o}, 64'd0);
    @(posedge clk);
    #1;
    flush40   = 1'b0;
    valid40_i = 1'b0;
    check("flush dropped beats", 64'(q40.size()), 64'd2);
    q40.delete();
    @(negedge clk);
    check("after flush valid_o", {63'd0, valid40_o}, 64'd0);
    check("after flush ready_o", {63'd0, ready40_o}, 64'd1);
    check("after flush beat_o",  {62'd0, beat40_o},  64'd0);
    repeat (3) @(negedge clk);
    check("flush word not captured", {63'd0, valid40_o}, 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-word.
    send40(WordB, waited);
    valid40_i = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset busy", {63'd0, valid40_o}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset valid_o", {63'd0, valid40_o}, 64'd0);
    check("async reset ready_o", {63'd0, ready40_o}, 64'd1);
    check("async reset beat_o",  {62'd0, beat40_o},  64'd0);
    q40.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat config, sustained one word per cycle.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] w;
      w = (i == 0) ? 8'h5A : (i == 1) ? 8'hC3 : 8'h0F;
      data8_i  = w;
      valid8_i = 1'b1;
      @(negedge clk);
      check("ready8 sustained", {63'd0, ready8_o}, 64'd1);
      if (ready8_o) q8.push_back({1'b1, 1'b0, w});
      @(posedge clk);
      #1;
    end
    valid8_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("beat8 queue drained", 64'(q8.size()), 64'd0);
    check("beat8 run length", 64'(last_run8), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
